// File: rtl/mips_pkg.sv
// Shared MIPS front-end types: machine word and the prefetch entry carried
// from the instruction-memory response side to the IF/DEC register.
package mips_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        word_t instr;
        word_t pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular prefetch buffer with synchronous clear; push while full is
// legal only together with a pop in the same cycle.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  entry_t                       push_data,
    input  logic                         pop,
    output entry_t                       pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: the count alone says which slots are live.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC generation, credit-limited imem requests,
// prefetch FIFO and IF/DEC register. Optional perf counters: FETCH_PERF_CNT_EN.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_IF,
    input  logic        stall_DEC,
    input  logic        redirect_EXE,
    input  logic [31:0] redirect_pc_EXE,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] instr_DEC,
    output logic [31:0] pc_DEC,
    output logic        valid_DEC
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped
`endif
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    word_t            pc;
    word_t            rsp_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             req_fire;
    logic             rsp_drop;
    logic             fifo_push;
    logic             fifo_pop;
    fetch_entry_t     push_entry;
    fetch_entry_t     pop_entry;

    // Every in-flight request already owns a FIFO slot, so responses never overflow.
    assign imem_req_valid = !reset && !stall_IF && !redirect_EXE &&
                            ((SUM_W'(outstanding) + SUM_W'(fifo_count)) < SUM_W'(FIFO_DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop   = imem_rsp_valid && (redirect_EXE || (drop_cnt != '0));
    assign fifo_push  = imem_rsp_valid && !rsp_drop;
    assign fifo_pop   = !stall_DEC && !redirect_EXE && !fifo_empty;
    assign push_entry = '{instr: imem_rsp_data, pc: rsp_pc};

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect_EXE),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (pop_entry),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(fifo_push && fifo_full && !fifo_pop));

    // PC, response tagging and in-flight bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            if (redirect_EXE)  pc <= redirect_pc_EXE;
            else if (req_fire) pc <= pc + 32'(INSTR_BYTES);

            if (redirect_EXE)   rsp_pc <= redirect_pc_EXE;
            else if (fifo_push) rsp_pc <= rsp_pc + 32'(INSTR_BYTES);

            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

            // Responses still in flight at a redirect belong to the wrong path.
            if (redirect_EXE)
                drop_cnt <= outstanding - CNT_W'(imem_rsp_valid);
            else if (imem_rsp_valid && (drop_cnt != '0))
                drop_cnt <= drop_cnt - CNT_W'(1);
        end
    end

    // IF/DEC pipeline register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_DEC <= '0;
            pc_DEC    <= '0;
            valid_DEC <= 1'b0;
        end else if (redirect_EXE) begin
            valid_DEC <= 1'b0;
        end else if (!stall_DEC) begin
            if (!fifo_empty) begin
                instr_DEC <= pop_entry.instr;
                pc_DEC    <= pop_entry.pc;
                valid_DEC <= 1'b1;
            end else begin
                valid_DEC <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Dropped work covers filtered responses and FIFO entries flushed by a redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            if (fifo_push) perf_fetched <= perf_fetched + 32'd1;
            perf_dropped <= perf_dropped + 32'(rsp_drop) +
                            (redirect_EXE ? 32'(fifo_count) : 32'd0);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order variable-latency memory
// model; a second instance starts at 0xFFFF_FFF8 to exercise PC wrap.
module tb_fetch_stage;
    import mips_pkg::*;

    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        stall_IF;
    logic        stall_DEC;
    logic        redirect_EXE;
    logic [31:0] redirect_pc_EXE;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instr_DEC;
    logic [31:0] pc_DEC;
    logic        valid_DEC;

    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_rsp_valid;
    logic [31:0] w_rsp_data;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic        w_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
    logic [31:0] w_perf_fetched;
    logic [31:0] w_perf_dropped;
    logic [31:0] dropped_base;
`endif

    fetch_stage u_dut (
        .clk             (clk),
        .reset           (reset),
        .stall_IF        (stall_IF),
        .stall_DEC       (stall_DEC),
        .redirect_EXE    (redirect_EXE),
        .redirect_pc_EXE (redirect_pc_EXE),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .instr_DEC       (instr_DEC),
        .pc_DEC          (pc_DEC),
        .valid_DEC       (valid_DEC)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_dropped    (perf_dropped)
`endif
    );

    fetch_stage #(.RESET_PC(WRAP_PC)) u_wrap (
        .clk             (clk),
        .reset           (reset),
        .stall_IF        (1'b0),
        .stall_DEC       (1'b0),
        .redirect_EXE    (1'b0),
        .redirect_pc_EXE (32'h0),
        .imem_req_valid  (w_req_valid),
        .imem_req_addr   (w_req_addr),
        .imem_req_ready  (1'b1),
        .imem_rsp_valid  (w_rsp_valid),
        .imem_rsp_data   (w_rsp_data),
        .instr_DEC       (w_instr),
        .pc_DEC          (w_pc),
        .valid_DEC       (w_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched    (w_perf_fetched),
        .perf_dropped    (w_perf_dropped)
`endif
    );

    int          checks   = 0;
    int          failures = 0;
    int          lat      = 1;
    int          cyc      = 0;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic        w_acc_prev;
    logic [31:0] w_addr_prev;
    logic [31:0] w_seen[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    logic [31:0] last_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h2400_A5A5;
    endfunction

    // One clock cycle: drive responses, observe requests, advance models, check DEC.
    task automatic tick();
        logic        acc;
        logic        w_acc;
        logic        redir;
        logic        sdec;
        logic [31:0] acc_addr;
        logic [31:0] w_addr;
        logic [31:0] tgt;
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memf(mq_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        w_rsp_valid = w_acc_prev;
        w_rsp_data  = memf(w_addr_prev);
        #1;
        acc      = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        w_acc    = w_req_valid;
        w_addr   = w_req_addr;
        redir    = redirect_EXE;
        sdec     = stall_DEC;
        tgt      = redirect_pc_EXE;
        if (redir) check("req_during_redirect", 32'(acc), 32'd0);
        if (acc) begin
            check("req_addr", acc_addr, exp_req);
            exp_req = exp_req + 32'd4;
        end
        @(posedge clk);
        if (imem_rsp_valid) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (acc) begin
            mq_addr.push_back(acc_addr);
            mq_due.push_back(cyc + lat);
        end
        if (w_acc) w_seen.push_back(w_addr);
        w_acc_prev  = w_acc;
        w_addr_prev = w_addr;
        cyc++;
        #1;
        if (redir) begin
            check("valid_after_redirect", 32'(valid_DEC), 32'd0);
            exp_pc  = tgt;
            exp_req = tgt;
        end else if (sdec) begin
            check("pc_hold", pc_DEC, last_pc);
        end else if (valid_DEC) begin
            check("dec_pc", pc_DEC, exp_pc);
            check("dec_instr", instr_DEC, memf(exp_pc));
            last_pc = exp_pc;
            exp_pc  = exp_pc + 32'd4;
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!valid_DEC && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(valid_DEC), 32'd1);
    endtask

    task automatic clear_models();
        mq_addr.delete();
        mq_due.delete();
        w_acc_prev  = 1'b0;
        w_addr_prev = '0;
        exp_pc      = 32'h0;
        exp_req     = 32'h0;
        last_pc     = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset           = 1'b1;
        stall_IF        = 1'b0;
        stall_DEC       = 1'b0;
        redirect_EXE    = 1'b0;
        redirect_pc_EXE = '0;
        imem_req_ready  = 1'b1;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = '0;
        w_rsp_valid     = 1'b0;
        w_rsp_data      = '0;
        clear_models();
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        check("rst_wrap_addr", w_req_addr, WRAP_PC);
        check("rst_valid_dec", 32'(valid_DEC), 32'd0);
        check("rst_pc_dec", pc_DEC, 32'h0);
        check("rst_instr_dec", instr_DEC, 32'h0);

        // Reset release, single-cycle memory.
        reset = 1'b0;
        #1;
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, 32'h0);
        tick();
        tick();
        check("latency_valid_low", 32'(valid_DEC), 32'd0);
        tick();
        check("latency_valid_high", 32'(valid_DEC), 32'd1);
        check("latency_pc", pc_DEC, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetched_early", perf_fetched, 32'd2);
        check("perf_dropped_early", perf_dropped, 32'd0);
`endif
        repeat (8) tick();
        check("wrap_count", 32'(w_seen.size() >= 3), 32'd1);
        if (w_seen.size() >= 3) begin
            check("wrap_addr0", w_seen[0], 32'hFFFF_FFF8);
            check("wrap_addr1", w_seen[1], 32'hFFFF_FFFC);
            check("wrap_addr2", w_seen[2], 32'h0000_0000);
        end

        // stall_DEC held 4 cycles: FIFO fills, credit closes, stream resumes gap-free.
        stall_DEC = 1'b1;
        repeat (4) tick();
        check("credit_stop", 32'(imem_req_valid), 32'd0);
        stall_DEC = 1'b0;
        tick();
        check("resume_valid0", 32'(valid_DEC), 32'd1);
        tick();
        check("resume_valid1", 32'(valid_DEC), 32'd1);

        // Redirect to 0x100 with two requests outstanding on a 3-cycle memory.
        stall_IF = 1'b1;
        #1;
        check("stall_if_blocks", 32'(imem_req_valid), 32'd0);
        repeat (6) tick();
        stall_IF = 1'b0;
        lat      = 3;
        tick();
        tick();
        check("credit_l3", 32'(imem_req_valid), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        dropped_base = perf_dropped;
`endif
        redirect_EXE    = 1'b1;
        redirect_pc_EXE = 32'h100;
        tick();
        redirect_EXE = 1'b0;
        check("redir_addr", imem_req_addr, 32'h100);
        check("redir_noreq", 32'(imem_req_valid), 32'd0);
        tick();
        tick();
`ifdef FETCH_PERF_CNT_EN
        check("perf_dropped_redir", perf_dropped - dropped_base, 32'd2);
`endif
        wait_valid("redir_valid_timeout");
        check("redir_first_pc", pc_DEC, 32'h100);

        // Redirect and stall_IF together.
        lat = 1;
        repeat (4) tick();
        redirect_EXE    = 1'b1;
        redirect_pc_EXE = 32'h200;
        stall_IF        = 1'b1;
        tick();
        redirect_EXE = 1'b0;
        tick();
        tick();
        check("stall_redir_addr", imem_req_addr, 32'h200);
        check("stall_redir_noreq", 32'(imem_req_valid), 32'd0);
        stall_IF = 1'b0;
        #1;
        check("stall_redir_req", 32'(imem_req_valid), 32'd1);
        wait_valid("stall_redir_timeout");
        check("stall_redir_pc", pc_DEC, 32'h200);

        // Asynchronous reset in the middle of a cycle.
        repeat (4) tick();
        #2;
        reset = 1'b1;
        #1;
        check("midrst_req_valid", 32'(imem_req_valid), 32'd0);
        check("midrst_req_addr", imem_req_addr, 32'h0);
        check("midrst_valid_dec", 32'(valid_DEC), 32'd0);
        check("midrst_pc_dec", pc_DEC, 32'h0);
        check("midrst_instr_dec", instr_DEC, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("midrst_perf_fetched", perf_fetched, 32'd0);
        check("midrst_perf_dropped", perf_dropped, 32'd0);
`endif
        clear_models();
        imem_rsp_valid = 1'b0;
        w_rsp_valid    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) tick();
        check("restart_valid", 32'(valid_DEC), 32'd1);
        check("restart_pc", pc_DEC, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
